// File: rtl/nios_hps_system_nios_key_pio_in.sv
// Avalon-MM input PIO for the Nios key/switch bank: synchronize, filter, capture edges, raise masked IRQ.
// Optional debounce filter is enabled by defining NIOS_KEY_PIO_DEBOUNCE_EN.

module nios_key_pio_lane #(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic clk,
    input  logic reset_n,
    input  logic din,
    output logic filt
);
    logic sync1_q, sync1_d;
    logic sync2_q, sync2_d;
    logic filt_q, filt_d;

`ifdef NIOS_KEY_PIO_DEBOUNCE_EN
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        sync1_d = din;
        sync2_d = sync1_q;
        filt_d  = filt_q;
        cnt_d   = '0;
        // filt only follows sync2 once the mismatch has persisted long enough
        if (sync2_q != filt_q) begin
            if (cnt_q == CW'(DEBOUNCE_CYCLES - 1)) filt_d = sync2_q;
            else                                   cnt_d  = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) cnt_q <= '0;
        else          cnt_q <= cnt_d;
    end
`else
    localparam int DB_UNUSED = DEBOUNCE_CYCLES;

    always_comb begin
        sync1_d = din;
        sync2_d = sync1_q;
        filt_d  = sync2_q;
    end
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            filt_q  <= 1'b0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            filt_q  <= filt_d;
        end
    end

    assign filt = filt_q;
endmodule

module nios_hps_system_nios_key_pio_in #(
    parameter int WIDTH           = 4,
    parameter int EDGE_TYPE       = 1,
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    input  logic [WIDTH-1:0] in_port,
    output logic [31:0]      readdata,
    output logic             irq
);
    logic [WIDTH-1:0] filt;
    logic [WIDTH-1:0] prev_q, prev_d;
    logic [WIDTH-1:0] mask_q, mask_d;
    logic [WIDTH-1:0] cap_q, cap_d;
    logic [1:0]       arm_q, arm_d;
    logic [31:0]      readdata_q, readdata_d;
    logic             irq_q, irq_d;
    logic [WIDTH-1:0] edg, clr;
    logic             wr_en;
    logic             wdata_unused;

    assign wdata_unused = ^writedata;

    for (genvar i = 0; i < WIDTH; i++) begin : g_lane
        nios_key_pio_lane #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_lane (
            .clk     (clk),
            .reset_n (reset_n),
            .din     (in_port[i]),
            .filt    (filt[i])
        );
    end

    assign wr_en = chipselect && !write_n;

    always_comb begin
        case (EDGE_TYPE)
            0:       edg = filt & ~prev_q;
            1:       edg = ~filt & prev_q;
            default: edg = filt ^ prev_q;
        endcase
        clr = (wr_en && address == 2'd3) ? writedata[WIDTH-1:0] : '0;

        prev_d = filt;
        // armed only once the counter saturates, so levels present at reset release are not events
        arm_d  = (arm_q == 2'd3) ? arm_q : arm_q + 2'd1;
        mask_d = (wr_en && address == 2'd2) ? writedata[WIDTH-1:0] : mask_q;
        // set has priority over a same-cycle clear
        cap_d  = (cap_q & ~clr) | ((arm_q == 2'd3) ? edg : '0);
        irq_d  = |(cap_q & mask_q);

        readdata_d = '0;
        case (address)
            2'd0:    readdata_d[WIDTH-1:0] = filt;
            2'd2:    readdata_d[WIDTH-1:0] = mask_q;
            2'd3:    readdata_d[WIDTH-1:0] = cap_q;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            prev_q     <= '0;
            arm_q      <= '0;
            mask_q     <= '0;
            cap_q      <= '0;
            irq_q      <= 1'b0;
            readdata_q <= '0;
        end else begin
            prev_q     <= prev_d;
            arm_q      <= arm_d;
            mask_q     <= mask_d;
            cap_q      <= cap_d;
            irq_q      <= irq_d;
            readdata_q <= readdata_d;
        end
    end

    assign readdata = readdata_q;
    assign irq      = irq_q;
endmodule
